issue_queue_int: RTL and testbench

- Integer issue queue: the receiving end of the decoder's integer dispatch interface (`Dispatch_en_integer`, `Dispatch_opcode`, `Dispatch_shfamt`).
- Buffers up to DEPTH dispatched integer instructions in age order and snoops the CDB (common data bus) for missing source operands.
- Issues the oldest fully-ready entry to the integer ALU under a valid/ready handshake.
- Sits between the dispatch unit and the integer ALU in the out-of-order core.

---
 rtl/mips_core_pkg.sv | 30 +++
 rtl/issue_queue_int_if.sv | 48 ++++
 rtl/int_issue_select.sv | 21 ++
 rtl/issue_queue_int.sv | 149 ++++++++++++++
 tb/tb_issue_queue_int.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_core_pkg.sv
// Shared integer-pipeline types: ALU opcodes, default tag/data widths and the
// issue-queue entry record.
package mips_core_pkg;

  localparam int IQ_TAG_W  = 6;
  localparam int IQ_DATA_W = 32;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic                 valid;
    logic [2:0]           opcode;
    logic [4:0]           shfamt;
    logic                 rs_val;
    logic [IQ_TAG_W-1:0]  rs_tag;
    logic [IQ_DATA_W-1:0] rs_data;
    logic                 rt_val;
    logic [IQ_TAG_W-1:0]  rt_tag;
    logic [IQ_DATA_W-1:0] rt_data;
    logic [IQ_TAG_W-1:0]  rd_tag;
  } iq_entry_t;

endpackage

// File: rtl/issue_queue_int_if.sv
// Dispatch, CDB and issue signals of the integer issue queue.
// slave = queue side, master = dispatch/CDB/ALU side.
interface issue_queue_int_if
  import mips_core_pkg::*;
#(
  parameter int TAG_W  = IQ_TAG_W,
  parameter int DATA_W = IQ_DATA_W
);
  logic              Dispatch_en_integer;
  logic [2:0]        Dispatch_opcode;
  logic [4:0]        Dispatch_shfamt;
  logic [DATA_W-1:0] Dispatch_rs_data;
  logic [DATA_W-1:0] Dispatch_rt_data;
  logic              Dispatch_rs_val;
  logic              Dispatch_rt_val;
  logic [TAG_W-1:0]  Dispatch_rs_tag;
  logic [TAG_W-1:0]  Dispatch_rt_tag;
  logic [TAG_W-1:0]  Dispatch_rd_tag;
  logic              Issueque_int_full;
  logic              CDB_valid;
  logic [TAG_W-1:0]  CDB_tag;
  logic [DATA_W-1:0] CDB_data;
  logic              Issue_ready;
  logic              Issue_valid;
  logic [2:0]        Issue_opcode;
  logic [4:0]        Issue_shfamt;
  logic [DATA_W-1:0] Issue_rs_data;
  logic [DATA_W-1:0] Issue_rt_data;
  logic [TAG_W-1:0]  Issue_rd_tag;

  modport slave (
    input  Dispatch_en_integer, Dispatch_opcode, Dispatch_shfamt,
           Dispatch_rs_data, Dispatch_rt_data, Dispatch_rs_val, Dispatch_rt_val,
           Dispatch_rs_tag, Dispatch_rt_tag, Dispatch_rd_tag,
           CDB_valid, CDB_tag, CDB_data, Issue_ready,
    output Issueque_int_full, Issue_valid, Issue_opcode, Issue_shfamt,
           Issue_rs_data, Issue_rt_data, Issue_rd_tag
  );

  modport master (
    output Dispatch_en_integer, Dispatch_opcode, Dispatch_shfamt,
           Dispatch_rs_data, Dispatch_rt_data, Dispatch_rs_val, Dispatch_rt_val,
           Dispatch_rs_tag, Dispatch_rt_tag, Dispatch_rd_tag,
           CDB_valid, CDB_tag, CDB_data, Issue_ready,
    input  Issueque_int_full, Issue_valid, Issue_opcode, Issue_shfamt,
           Issue_rs_data, Issue_rt_data, Issue_rd_tag
  );
endinterface

// File: rtl/int_issue_select.sv
// Oldest-ready picker: index of the lowest set bit of a ready vector.
module int_issue_select #(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0]         ready,
  output logic                     found,
  output logic [$clog2(DEPTH)-1:0] idx
);
  localparam int IDX_W = $clog2(DEPTH);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end
endmodule

// File: rtl/issue_queue_int.sv
// Integer issue queue: age-ordered compacting buffer with CDB wakeup and
// oldest-ready issue. Optional Flush port under ISSUEQ_INT_FLUSH_EN.
module issue_queue_int
  import mips_core_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = IQ_TAG_W,
  parameter int DATA_W = IQ_DATA_W
) (
  input logic clock,
  input logic reset,
`ifdef ISSUEQ_INT_FLUSH_EN
  input logic Flush,
`endif
  issue_queue_int_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic              valid;
    logic [2:0]        opcode;
    logic [4:0]        shfamt;
    logic              rs_val;
    logic [TAG_W-1:0]  rs_tag;
    logic [DATA_W-1:0] rs_data;
    logic              rt_val;
    logic [TAG_W-1:0]  rt_tag;
    logic [DATA_W-1:0] rt_data;
    logic [TAG_W-1:0]  rd_tag;
  } entry_t;

  entry_t           q   [DEPTH];
  entry_t           q_n [DEPTH];
  entry_t           new_e;
  logic [CNT_W-1:0] count, count_n, wr_pos;
  logic             full_q;
  logic [DEPTH-1:0] ready_vec;
  logic             found, offer, accept, fire, flush;
  logic [IDX_W-1:0] sel_idx;
  logic             rs_byp, rt_byp;

`ifdef ISSUEQ_INT_FLUSH_EN
  assign flush = Flush;
`else
  assign flush = 1'b0;
`endif

  always_comb begin
    ready_vec = '0;
    for (int i = 0; i < DEPTH; i++)
      ready_vec[i] = q[i].valid & q[i].rs_val & q[i].rt_val;
  end

  int_issue_select #(.DEPTH(DEPTH)) u_select (
    .ready (ready_vec),
    .found (found),
    .idx   (sel_idx)
  );

  assign offer  = found & ~flush;
  assign fire   = offer & bus.Issue_ready;
  // A same-cycle issue does not make room: acceptance looks at count only.
  assign accept = bus.Dispatch_en_integer & (count != CNT_W'(DEPTH));

  always_comb begin
    bus.Issue_valid   = offer;
    bus.Issue_opcode  = '0;
    bus.Issue_shfamt  = '0;
    bus.Issue_rs_data = '0;
    bus.Issue_rt_data = '0;
    bus.Issue_rd_tag  = '0;
    if (offer) begin
      bus.Issue_opcode  = q[sel_idx].opcode;
      bus.Issue_shfamt  = q[sel_idx].shfamt;
      bus.Issue_rs_data = q[sel_idx].rs_data;
      bus.Issue_rt_data = q[sel_idx].rt_data;
      bus.Issue_rd_tag  = q[sel_idx].rd_tag;
    end
  end

  assign rs_byp = ~bus.Dispatch_rs_val & bus.CDB_valid & (bus.Dispatch_rs_tag == bus.CDB_tag);
  assign rt_byp = ~bus.Dispatch_rt_val & bus.CDB_valid & (bus.Dispatch_rt_tag == bus.CDB_tag);

  always_comb begin
    new_e         = '0;
    new_e.valid   = 1'b1;
    new_e.opcode  = bus.Dispatch_opcode;
    new_e.shfamt  = bus.Dispatch_shfamt;
    new_e.rs_val  = bus.Dispatch_rs_val | rs_byp;
    new_e.rs_tag  = bus.Dispatch_rs_tag;
    new_e.rs_data = rs_byp ? bus.CDB_data : bus.Dispatch_rs_data;
    new_e.rt_val  = bus.Dispatch_rt_val | rt_byp;
    new_e.rt_tag  = bus.Dispatch_rt_tag;
    new_e.rt_data = rt_byp ? bus.CDB_data : bus.Dispatch_rt_data;
    new_e.rd_tag  = bus.Dispatch_rd_tag;
  end

  always_comb begin
    q_n     = q;
    count_n = count;
    wr_pos  = count - CNT_W'(fire);
    for (int i = 0; i < DEPTH; i++) begin
      if (q[i].valid && bus.CDB_valid) begin
        if (!q[i].rs_val && q[i].rs_tag == bus.CDB_tag) begin
          q_n[i].rs_val  = 1'b1;
          q_n[i].rs_data = bus.CDB_data;
        end
        if (!q[i].rt_val && q[i].rt_tag == bus.CDB_tag) begin
          q_n[i].rt_val  = 1'b1;
          q_n[i].rt_data = bus.CDB_data;
        end
      end
    end
    // Compaction: everything younger than the issued entry moves down one slot.
    if (fire) begin
      for (int i = 0; i < DEPTH - 1; i++)
        if (IDX_W'(i) >= sel_idx) q_n[i] = q_n[i+1];
      q_n[DEPTH-1] = '0;
    end
    if (accept) begin
      for (int i = 0; i < DEPTH; i++)
        if (CNT_W'(i) == wr_pos) q_n[i] = new_e;
    end
    case ({accept, fire})
      2'b10:   count_n = count + 1'b1;
      2'b01:   count_n = count - 1'b1;
      default: count_n = count;
    endcase
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) q_n[i] = '0;
      count_n = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      count  <= '0;
      full_q <= 1'b0;
    end else begin
      q      <= q_n;
      count  <= count_n;
      full_q <= (count_n == CNT_W'(DEPTH));
    end
  end

  assign bus.Issueque_int_full = full_q;
endmodule

// File: tb/tb_issue_queue_int.sv
// Bench for issue_queue_int: vector table, corner sequences and a random run
// against a queue-based model. Flush checks compile in with ISSUEQ_INT_FLUSH_EN.
module tb_issue_queue_int;
  import mips_core_pkg::*;

  localparam int DEPTH = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clock = ~clock;

  issue_queue_int_if #(.TAG_W(IQ_TAG_W), .DATA_W(IQ_DATA_W)) bus ();

  issue_queue_int #(.DEPTH(DEPTH), .TAG_W(IQ_TAG_W), .DATA_W(IQ_DATA_W)) dut (
    .clock (clock),
    .reset (reset),
`ifdef ISSUEQ_INT_FLUSH_EN
    .Flush (flush),
`endif
    .bus   (bus)
  );

  iq_entry_t mq[$];

  typedef struct {
    logic        en;
    logic [2:0]  op;
    logic        rsv;
    logic [31:0] rsd;
    logic [5:0]  rstag;
    logic        rtv;
    logic [31:0] rtd;
    logic [5:0]  rttag;
    logic [5:0]  rd;
    logic        cdbv;
    logic [5:0]  cdbt;
    logic [31:0] cdbd;
    logic        rdy;
    logic        ev;
    logic [31:0] ers;
    logic [31:0] ert;
    logic [5:0]  erd;
    logic        efull;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.Dispatch_en_integer = 1'b0;
    bus.CDB_valid           = 1'b0;
    flush                   = 1'b0;
  endtask

  task automatic drive_dispatch(input logic [2:0] op, input logic [4:0] sh,
                                input logic rsv, input logic [31:0] rsd, input logic [5:0] rst,
                                input logic rtv, input logic [31:0] rtd, input logic [5:0] rtt,
                                input logic [5:0] rd);
    bus.Dispatch_en_integer = 1'b1;
    bus.Dispatch_opcode     = op;
    bus.Dispatch_shfamt     = sh;
    bus.Dispatch_rs_val     = rsv;
    bus.Dispatch_rs_data    = rsd;
    bus.Dispatch_rs_tag     = rst;
    bus.Dispatch_rt_val     = rtv;
    bus.Dispatch_rt_data    = rtd;
    bus.Dispatch_rt_tag     = rtt;
    bus.Dispatch_rd_tag     = rd;
  endtask

  function automatic int oldest_ready();
    for (int i = 0; i < mq.size(); i++)
      if (mq[i].rs_val && mq[i].rt_val) return i;
    return -1;
  endfunction

  // Model of one clock edge from the inputs currently driven.
  task automatic model_update();
    int        sel;
    bit        fire, acc;
    iq_entry_t e;
    sel  = oldest_ready();
    fire = (sel >= 0) && bus.Issue_ready && !flush;
    acc  = bus.Dispatch_en_integer && (mq.size() < DEPTH);
    if (flush) begin
      mq.delete();
      return;
    end
    if (bus.CDB_valid) begin
      for (int i = 0; i < mq.size(); i++) begin
        if (!mq[i].rs_val && mq[i].rs_tag == bus.CDB_tag) begin
          mq[i].rs_val = 1'b1; mq[i].rs_data = bus.CDB_data;
        end
        if (!mq[i].rt_val && mq[i].rt_tag == bus.CDB_tag) begin
          mq[i].rt_val = 1'b1; mq[i].rt_data = bus.CDB_data;
        end
      end
    end
    if (fire) mq.delete(sel);
    if (acc) begin
      e         = '0;
      e.valid   = 1'b1;
      e.opcode  = bus.Dispatch_opcode;
      e.shfamt  = bus.Dispatch_shfamt;
      e.rs_val  = bus.Dispatch_rs_val;
      e.rs_tag  = bus.Dispatch_rs_tag;
      e.rs_data = bus.Dispatch_rs_data;
      e.rt_val  = bus.Dispatch_rt_val;
      e.rt_tag  = bus.Dispatch_rt_tag;
      e.rt_data = bus.Dispatch_rt_data;
      e.rd_tag  = bus.Dispatch_rd_tag;
      if (!e.rs_val && bus.CDB_valid && e.rs_tag == bus.CDB_tag) begin
        e.rs_val = 1'b1; e.rs_data = bus.CDB_data;
      end
      if (!e.rt_val && bus.CDB_valid && e.rt_tag == bus.CDB_tag) begin
        e.rt_val = 1'b1; e.rt_data = bus.CDB_data;
      end
      mq.push_back(e);
    end
  endtask

  task automatic check_model(input string tag);
    int sel;
    sel = oldest_ready();
    chk({tag, "_valid"}, bus.Issue_valid, (sel >= 0) && !flush);
    if (sel >= 0 && !flush) begin
      chk({tag, "_op"}, bus.Issue_opcode,  mq[sel].opcode);
      chk({tag, "_sh"}, bus.Issue_shfamt,  mq[sel].shfamt);
      chk({tag, "_rs"}, bus.Issue_rs_data, mq[sel].rs_data);
      chk({tag, "_rt"}, bus.Issue_rt_data, mq[sel].rt_data);
      chk({tag, "_rd"}, bus.Issue_rd_tag,  mq[sel].rd_tag);
    end else begin
      chk({tag, "_zero"}, {bus.Issue_opcode, bus.Issue_shfamt, bus.Issue_rd_tag,
                           bus.Issue_rs_data[15:0], bus.Issue_rt_data[15:0]}, 64'd0);
    end
    chk({tag, "_full"}, bus.Issueque_int_full, mq.size() == DEPTH);
  endtask

  task automatic step(input string tag);
    model_update();
    @(posedge clock);
    #1;
    idle();
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    mq.delete();
    #1;
    chk("reset_valid", bus.Issue_valid, 1'b0);
    chk("reset_full",  bus.Issueque_int_full, 1'b0);
    chk("reset_data",  {bus.Issue_rs_data, bus.Issue_rt_data}, 64'd0);
    chk("reset_rd",    {bus.Issue_opcode, bus.Issue_shfamt, bus.Issue_rd_tag}, 64'd0);
  endtask

  initial begin
    bus.Issue_ready      = 1'b0;
    bus.CDB_tag          = '0;
    bus.CDB_data         = '0;
    bus.Dispatch_opcode  = '0;
    bus.Dispatch_shfamt  = '0;
    bus.Dispatch_rs_val  = 1'b0;
    bus.Dispatch_rs_data = '0;
    bus.Dispatch_rs_tag  = '0;
    bus.Dispatch_rt_val  = 1'b0;
    bus.Dispatch_rt_data = '0;
    bus.Dispatch_rt_tag  = '0;
    bus.Dispatch_rd_tag  = '0;
    idle();

    //            en   op      rsv  rsd      rstag  rtv  rtd      rttag  rd     cdbv cdbt   cdbd        rdy  ev   ers          ert      erd    full
    vecs[0]  = '{1'b1, ALU_AND, 1'b1, 32'd5,  6'd0,  1'b1, 32'd7,  6'd0,  6'd3, 1'b0, 6'd0,  32'd0,      1'b1, 1'b1, 32'd5,      32'd7,   6'd3, 1'b0};
    vecs[1]  = '{1'b0, ALU_ADD, 1'b0, 32'd0,  6'd0,  1'b0, 32'd0,  6'd0,  6'd0, 1'b0, 6'd0,  32'd0,      1'b1, 1'b0, 32'd0,      32'd0,   6'd0, 1'b0};
    vecs[2]  = '{1'b1, ALU_ADD, 1'b0, 32'd0,  6'd9,  1'b1, 32'h22, 6'd0,  6'd4, 1'b0, 6'd0,  32'd0,      1'b1, 1'b0, 32'd0,      32'd0,   6'd0, 1'b0};
    vecs[3]  = '{1'b0, ALU_ADD, 1'b0, 32'd0,  6'd0,  1'b0, 32'd0,  6'd0,  6'd0, 1'b0, 6'd0,  32'd0,      1'b1, 1'b0, 32'd0,      32'd0,   6'd0, 1'b0};
    vecs[4]  = '{1'b0, ALU_ADD, 1'b0, 32'd0,  6'd0,  1'b0, 32'd0,  6'd0,  6'd0, 1'b1, 6'd9,  32'h1234,   1'b1, 1'b1, 32'h1234,   32'h22,  6'd4, 1'b0};
    vecs[5]  = '{1'b0, ALU_ADD, 1'b0, 32'd0,  6'd0,  1'b0, 32'd0,  6'd0,  6'd0, 1'b0, 6'd0,  32'd0,      1'b1, 1'b0, 32'd0,      32'd0,   6'd0, 1'b0};
    vecs[6]  = '{1'b1, ALU_SUB, 1'b1, 32'd1,  6'd0,  1'b0, 32'd0,  6'd12, 6'd5, 1'b1, 6'd12, 32'hFF,     1'b0, 1'b1, 32'd1,      32'hFF,  6'd5, 1'b0};
    vecs[7]  = '{1'b0, ALU_ADD, 1'b0, 32'd0,  6'd0,  1'b0, 32'd0,  6'd0,  6'd0, 1'b0, 6'd0,  32'd0,      1'b1, 1'b0, 32'd0,      32'd0,   6'd0, 1'b0};
    vecs[8]  = '{1'b1, ALU_OR,  1'b0, 32'd0,  6'd20, 1'b1, 32'hA,  6'd0,  6'd6, 1'b0, 6'd0,  32'd0,      1'b1, 1'b0, 32'd0,      32'd0,   6'd0, 1'b0};
    vecs[9]  = '{1'b1, ALU_XOR, 1'b1, 32'hB,  6'd0,  1'b1, 32'hC,  6'd0,  6'd7, 1'b0, 6'd0,  32'd0,      1'b1, 1'b1, 32'hB,      32'hC,   6'd7, 1'b0};
    vecs[10] = '{1'b0, ALU_ADD, 1'b0, 32'd0,  6'd0,  1'b0, 32'd0,  6'd0,  6'd0, 1'b1, 6'd20, 32'hAA,     1'b1, 1'b1, 32'hAA,     32'hA,   6'd6, 1'b0};
    vecs[11] = '{1'b0, ALU_ADD, 1'b0, 32'd0,  6'd0,  1'b0, 32'd0,  6'd0,  6'd0, 1'b0, 6'd0,  32'd0,      1'b1, 1'b0, 32'd0,      32'd0,   6'd0, 1'b0};

    repeat (2) @(posedge clock);
    #1;
    do_reset();

    for (int v = 0; v < 12; v++) begin
      if (vecs[v].en)
        drive_dispatch(vecs[v].op, 5'd0, vecs[v].rsv, vecs[v].rsd, vecs[v].rstag,
                       vecs[v].rtv, vecs[v].rtd, vecs[v].rttag, vecs[v].rd);
      bus.CDB_valid   = vecs[v].cdbv;
      bus.CDB_tag     = vecs[v].cdbt;
      bus.CDB_data    = vecs[v].cdbd;
      bus.Issue_ready = vecs[v].rdy;
      step($sformatf("vec%0d_model", v));
      chk($sformatf("vec%0d_valid", v), bus.Issue_valid, vecs[v].ev);
      chk($sformatf("vec%0d_rs", v), bus.Issue_rs_data, vecs[v].ers);
      chk($sformatf("vec%0d_rt", v), bus.Issue_rt_data, vecs[v].ert);
      chk($sformatf("vec%0d_rd", v), bus.Issue_rd_tag, vecs[v].erd);
      chk($sformatf("vec%0d_full", v), bus.Issueque_int_full, vecs[v].efull);
    end

    // Fill to full, drop a fifth dispatch, then drain in age order.
    bus.Issue_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_dispatch(ALU_ADD, 5'(k), 1'b1, 32'(k), 6'd0, 1'b1, 32'(k + 100), 6'd0, 6'(10 + k));
      step("fill");
      chk($sformatf("fill%0d_full", k), bus.Issueque_int_full, k == 3);
    end
    drive_dispatch(ALU_ADD, 5'd0, 1'b1, 32'd99, 6'd0, 1'b1, 32'd99, 6'd0, 6'd15);
    step("drop");
    chk("drop_full", bus.Issueque_int_full, 1'b1);
    bus.Issue_ready = 1'b1;
    step("drain0");
    chk("drain0_full", bus.Issueque_int_full, 1'b0);
    chk("drain0_rd", bus.Issue_rd_tag, 6'd11);
    step("drain1");
    chk("drain1_rd", bus.Issue_rd_tag, 6'd12);
    step("drain2");
    chk("drain2_rd", bus.Issue_rd_tag, 6'd13);
    step("drain3");
    chk("drain3_valid", bus.Issue_valid, 1'b0);

    // Issue and dispatch in the same cycle: new entry takes the freed position.
    bus.Issue_ready = 1'b0;
    drive_dispatch(ALU_SLL, 5'd3, 1'b1, 32'd30, 6'd0, 1'b1, 32'd31, 6'd0, 6'd30);
    step("sim0");
    bus.Issue_ready = 1'b1;
    drive_dispatch(ALU_SRL, 5'd4, 1'b1, 32'd40, 6'd0, 1'b1, 32'd41, 6'd0, 6'd31);
    step("sim1");
    chk("sim1_rd", bus.Issue_rd_tag, 6'd31);
    chk("sim1_sh", bus.Issue_shfamt, 5'd4);

    // Reset with live entries.
    bus.Issue_ready = 1'b0;
    drive_dispatch(ALU_SLT, 5'd0, 1'b1, 32'd1, 6'd0, 1'b1, 32'd2, 6'd0, 6'd33);
    step("prerst");
    do_reset();

`ifdef ISSUEQ_INT_FLUSH_EN
    bus.Issue_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive_dispatch(ALU_ADD, 5'd0, 1'b1, 32'(k), 6'd0, 1'b1, 32'(k), 6'd0, 6'(40 + k));
      step("fl_fill");
    end
    flush = 1'b1;
    drive_dispatch(ALU_ADD, 5'd0, 1'b1, 32'd9, 6'd0, 1'b1, 32'd9, 6'd0, 6'd50);
    #1;
    chk("flush_comb_valid", bus.Issue_valid, 1'b0);
    step("flush");
    chk("flush_valid", bus.Issue_valid, 1'b0);
    chk("flush_full", bus.Issueque_int_full, 1'b0);
    for (int k = 0; k < 4; k++) begin
      drive_dispatch(ALU_ADD, 5'd0, 1'b1, 32'(k), 6'd0, 1'b1, 32'(k), 6'd0, 6'(52 + k));
      step("fl_refill");
      chk($sformatf("fl_refill%0d_full", k), bus.Issueque_int_full, k == 3);
    end
    do_reset();
`endif

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 2) != 0)
        drive_dispatch(3'($urandom), 5'($urandom), 1'($urandom_range(0, 1)), $urandom,
                       6'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom,
                       6'($urandom_range(0, 7)), 6'($urandom));
      bus.CDB_valid   = 1'($urandom_range(0, 1));
      bus.CDB_tag     = 6'($urandom_range(0, 7));
      bus.CDB_data    = $urandom;
      bus.Issue_ready = ($urandom_range(0, 3) != 0);
`ifdef ISSUEQ_INT_FLUSH_EN
      flush = ($urandom_range(0, 49) == 0);
`endif
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
